// File: rtl/edge_window_generator_if.sv
// -----------------------------------------------------------------------------
// edge_window_generator_if
// Bundles the pixel input stream and the window output stream of
// edge_window_generator.
//   pix_valid, pix_data  : pixel stream into the block (raster order)
//   pix_ready            : block can accept a pixel this cycle
//   win_valid            : neighbors_state carries a window this cycle
//   neighbors_state[8:0] : 3x3 window around the current centre pixel
//   frame_done           : pulse with the last window of a frame
// Modports: master = pixel source / window sink, slave = the generator.
// -----------------------------------------------------------------------------
interface edge_window_generator_if;
    logic       pix_valid;
    logic       pix_data;
    logic       pix_ready;
    logic       win_valid;
    logic [8:0] neighbors_state;
    logic       frame_done;

    modport master (
        output pix_valid,
        output pix_data,
        input  pix_ready,
        input  win_valid,
        input  neighbors_state,
        input  frame_done
    );

    modport slave (
        input  pix_valid,
        input  pix_data,
        output pix_ready,
        output win_valid,
        output neighbors_state,
        output frame_done
    );
endinterface

// File: rtl/edge_window_generator.sv
// -----------------------------------------------------------------------------
// edge_window_generator
// Turns a raster-order stream of binary pixels into one 3x3 neighbourhood
// window per pixel, with out-of-image neighbours forced to 0.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : edge_window_generator_if.slave (pixel in, window out)
// Window bit order around centre (r,c):
//   0:(r-1,c-1) 1:(r-1,c) 2:(r-1,c+1) 3:(r,c+1) 4:(r+1,c+1)
//   5:(r+1,c)   6:(r+1,c-1) 7:(r,c-1) 8:(r,c)
// A window for centre k is produced once pixel k+IMG_W+1 has arrived; the
// last IMG_W+1 windows of a frame are produced by flushing zeros through.
// -----------------------------------------------------------------------------
module edge_window_generator #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    edge_window_generator_if.slave  bus
);

    localparam int SR_LEN = 2 * IMG_W + 3;
    localparam int CW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW     = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int FW     = $clog2(IMG_W + 1);

    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
    localparam logic [CW-1:0] COL_ONE   = CW'(1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_ONE   = RW'(1);
    localparam logic [FW-1:0] FLUSH_END = FW'(IMG_W);
    localparam logic [FW-1:0] FLUSH_ONE = FW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_RUN,
        S_FLUSH
    } state_t;

    state_t            state_reg, state_next;

    // Input position of the pixel currently offered, and centre of the next
    // window to emit.
    logic [CW-1:0]     in_col_reg, out_col_reg;
    logic [RW-1:0]     in_row_reg, out_row_reg;
    logic [FW-1:0]     flush_cnt_reg;

    logic [SR_LEN-1:0] sr_reg;
    logic [SR_LEN-1:0] sr_next;

    logic              ready;
    logic              accept;
    logic              emit;
    logic              shift_en;
    logic              shift_in;
    logic [8:0]        win_next;

    logic              win_valid_reg;
    logic [8:0]        neighbors_reg;
    logic              frame_done_reg;

    // -------------------------------------------------------------------------
    // Next storage contents: newest pixel at bit 0, oldest at the top.
    // -------------------------------------------------------------------------
    assign sr_next[0] = shift_in;
    generate
        for (genvar gi = 1; gi < SR_LEN; gi++) begin : g_shift
            assign sr_next[gi] = sr_reg[gi-1];
        end
    endgenerate

    // Storage is deliberately not reset; border masking hides stale bits.
    always_ff @(posedge clk) begin
        if (shift_en) begin
            sr_reg <= sr_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state and control
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        ready      = (state_reg != S_FLUSH);
        accept     = bus.pix_valid && ready;
        emit       = 1'b0;
        shift_in   = accept && bus.pix_data;
        shift_en   = accept;

        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    state_next = S_FILL;
                end
            end
            S_FILL: begin
                // Pixel idx IMG_W sits at (1,0); after it the first window
                // centre has its full lower neighbourhood one pixel away.
                if (accept && in_row_reg == ROW_ONE && in_col_reg == '0) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                emit = accept;
                if (accept && in_row_reg == ROW_LAST && in_col_reg == COL_LAST) begin
                    state_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                emit     = 1'b1;
                shift_en = 1'b1;
                if (flush_cnt_reg == FLUSH_END) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Window extraction with image-border padding
    // -------------------------------------------------------------------------
    always_comb begin
        logic top, bot, lft, rgt;
        top = (out_row_reg == '0);
        bot = (out_row_reg == ROW_LAST);
        lft = (out_col_reg == '0);
        rgt = (out_col_reg == COL_LAST);

        win_next    = '0;
        win_next[0] = sr_next[2*IMG_W+2] && !top && !lft;
        win_next[1] = sr_next[2*IMG_W+1] && !top;
        win_next[2] = sr_next[2*IMG_W]   && !top && !rgt;
        win_next[3] = sr_next[IMG_W]     && !rgt;
        win_next[4] = sr_next[0]         && !bot && !rgt;
        win_next[5] = sr_next[1]         && !bot;
        win_next[6] = sr_next[2]         && !bot && !lft;
        win_next[7] = sr_next[IMG_W+2]   && !lft;
        win_next[8] = sr_next[IMG_W+1];
    end

    // -------------------------------------------------------------------------
    // Counters
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_col_reg    <= '0;
            in_row_reg    <= '0;
            out_col_reg   <= '0;
            out_row_reg   <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (accept) begin
                if (in_col_reg == COL_LAST) begin
                    in_col_reg <= '0;
                    in_row_reg <= (in_row_reg == ROW_LAST) ? '0 : in_row_reg + ROW_ONE;
                end else begin
                    in_col_reg <= in_col_reg + COL_ONE;
                end
            end

            if (emit) begin
                if (out_col_reg == COL_LAST) begin
                    out_col_reg <= '0;
                    out_row_reg <= (out_row_reg == ROW_LAST) ? '0 : out_row_reg + ROW_ONE;
                end else begin
                    out_col_reg <= out_col_reg + COL_ONE;
                end
            end

            if (state_reg == S_FLUSH && flush_cnt_reg != FLUSH_END) begin
                flush_cnt_reg <= flush_cnt_reg + FLUSH_ONE;
            end else begin
                flush_cnt_reg <= '0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_valid_reg  <= 1'b0;
            neighbors_reg  <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            win_valid_reg  <= emit;
            frame_done_reg <= emit && out_row_reg == ROW_LAST && out_col_reg == COL_LAST;
            if (emit) begin
                neighbors_reg <= win_next;
            end
        end
    end

    assign bus.pix_ready       = ready;
    assign bus.win_valid       = win_valid_reg;
    assign bus.neighbors_state = neighbors_reg;
    assign bus.frame_done      = frame_done_reg;

endmodule

// File: tb/tb_edge_window_generator.sv
// -----------------------------------------------------------------------------
// tb_edge_window_generator
// Drives a 4x4 and a 5x3 instance of edge_window_generator with directed and
// random frames and checks every cycle against an image-level model: the
// expected window is read straight from the stored frame with zero padding,
// and window timing follows the acceptance-count rule.
// -----------------------------------------------------------------------------
module tb_edge_window_generator;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    edge_window_generator_if bus_a ();
    edge_window_generator_if bus_b ();

    edge_window_generator #(.IMG_W(4), .IMG_H(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    edge_window_generator #(.IMG_W(5), .IMG_H(3)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    int         sel      = 0;
    int         cur_w    = 4;
    int         cur_h    = 4;
    bit         img [0:31];
    logic [8:0] got_win [0:31];

    logic       o_rdy, o_wv, o_fd;
    logic [8:0] o_nb;
    assign o_rdy = (sel != 0) ? bus_b.pix_ready       : bus_a.pix_ready;
    assign o_wv  = (sel != 0) ? bus_b.win_valid       : bus_a.win_valid;
    assign o_fd  = (sel != 0) ? bus_b.frame_done      : bus_a.frame_done;
    assign o_nb  = (sel != 0) ? bus_b.neighbors_state : bus_a.neighbors_state;

    task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic d);
        if (sel != 0) begin
            bus_b.pix_valid = v;  bus_b.pix_data = d;
            bus_a.pix_valid = 1'b0; bus_a.pix_data = 1'b0;
        end else begin
            bus_a.pix_valid = v;  bus_a.pix_data = d;
            bus_b.pix_valid = 1'b0; bus_b.pix_data = 1'b0;
        end
    endtask

    // Pixel of the reference frame, zero outside the image.
    function automatic logic px(input int r, input int c);
        if (r < 0 || r >= cur_h || c < 0 || c >= cur_w) return 1'b0;
        return img[r*cur_w + c];
    endfunction

    function automatic logic [8:0] ref_window(input int k);
        int r, c;
        logic [8:0] w;
        r = k / cur_w;
        c = k % cur_w;
        w[0] = px(r-1, c-1);
        w[1] = px(r-1, c);
        w[2] = px(r-1, c+1);
        w[3] = px(r,   c+1);
        w[4] = px(r+1, c+1);
        w[5] = px(r+1, c);
        w[6] = px(r+1, c-1);
        w[7] = px(r,   c-1);
        w[8] = px(r,   c);
        return w;
    endfunction

    task automatic set_img(input int kind);
        for (int i = 0; i < 32; i++) begin
            case (kind)
                0:       img[i] = 1'b0;
                1:       img[i] = 1'b1;
                default: img[i] = 1'($urandom);
            endcase
        end
    endtask

    // mode 0: valid held high (also through flush), 1: toggling, 2: random.
    task automatic run_frame(input int mode);
        int   n, acc, flush_left, wins, cycles, k;
        logic v, d, acc_now, tog, exp_rdy;
        n = cur_w * cur_h;
        acc = 0; flush_left = 0; wins = 0; cycles = 0; tog = 1'b1;
        while (!(acc == n && flush_left == 0)) begin
            @(negedge clk);
            exp_rdy = (flush_left == 0);
            case (mode)
                0:       v = 1'b1;
                1:       begin v = tog; tog = ~tog; end
                default: v = 1'($urandom_range(0, 1));
            endcase
            d = (v && acc < n && exp_rdy) ? img[acc] : 1'($urandom);
            drive(v, d);
            #1;
            chk("pix_ready", {8'h0, o_rdy}, {8'h0, exp_rdy});
            acc_now = v && exp_rdy;
            @(posedge clk);
            #1;
            k = -1;
            if (flush_left > 0) begin
                k = wins;
                flush_left--;
            end else if (acc_now) begin
                if (acc >= cur_w + 1) k = acc - cur_w - 1;
                acc++;
                if (acc == n) flush_left = cur_w + 1;
            end
            chk("win_valid", {8'h0, o_wv}, {8'h0, (k >= 0)});
            chk("frame_done", {8'h0, o_fd}, {8'h0, (k == n - 1)});
            if (k >= 0) begin
                chk("neighbors", o_nb, ref_window(k));
                got_win[k] = o_nb;
                $display("dut%0d win %0d (r%0d,c%0d) nb=%h", sel, k, k / cur_w, k % cur_w, o_nb);
                wins++;
            end
            cycles++;
            if (cycles > 400) begin
                n_checks++;
                n_fail++;
                $error("FAIL timeout: observed %0d cycles expected frame end", cycles);
                break;
            end
        end
        chk("win_count", 9'(wins), 9'(n));
        drive(1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b0;
        bus_a.pix_valid = 1'b0; bus_a.pix_data = 1'b0;
        bus_b.pix_valid = 1'b0; bus_b.pix_data = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_wv_a", {8'h0, bus_a.win_valid}, 9'h0);
        chk("rst_fd_a", {8'h0, bus_a.frame_done}, 9'h0);
        chk("rst_nb_a", bus_a.neighbors_state, 9'h0);
        chk("rst_wv_b", {8'h0, bus_b.win_valid}, 9'h0);
        rst = 1'b1;
        #1;
        chk("rdy_after_rst", {8'h0, bus_a.pix_ready}, 9'h1);

        // 4x4 instance
        sel = 0; cur_w = 4; cur_h = 4;

        set_img(1);
        run_frame(0);
        chk("ones_w00", got_win[0],  9'b100111000);
        chk("ones_w11", got_win[5],  9'h1FF);
        chk("ones_w33", got_win[15], 9'b110000011);

        run_frame(1);
        chk("tog_w00", got_win[0],  9'b100111000);
        chk("tog_w11", got_win[5],  9'h1FF);
        chk("tog_w33", got_win[15], 9'b110000011);

        set_img(0);
        img[5] = 1'b1;
        run_frame(0);
        chk("dot_w11", got_win[5],  9'h100);
        chk("dot_w00", got_win[0],  9'h010);
        chk("dot_w22", got_win[10], 9'h001);
        chk("dot_w33", got_win[15], 9'h000);

        for (int f = 0; f < 3; f++) begin
            set_img(2);
            run_frame(2);
        end

        // Mid-frame reset after 7 accepted pixels of an all-ones frame.
        set_img(1);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b1);
            @(posedge clk);
        end
        #1;
        chk("pre_rst_wv", {8'h0, bus_a.win_valid}, 9'h1);
        rst = 1'b0;
        #1;
        chk("async_wv", {8'h0, bus_a.win_valid}, 9'h0);
        chk("async_nb", bus_a.neighbors_state, 9'h0);
        chk("async_fd", {8'h0, bus_a.frame_done}, 9'h0);
        drive(1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        set_img(0);
        run_frame(0);

        // 5x3 instance: non-power-of-two wrap points
        sel = 1; cur_w = 5; cur_h = 3;
        set_img(1);
        run_frame(0);
        for (int f = 0; f < 3; f++) begin
            set_img(2);
            run_frame(f);
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/edge_window_generator.md
EDGE_WINDOW_GENERATOR -- requirements
Module: edge_window_generator

Interface
- REQ-001 Parameter IMG_W, default 8: image width in pixels; SHALL be >= 2.
- REQ-002 Parameter IMG_H, default 8: image height in pixels; SHALL be >= 2.
- REQ-003 Port clk, input, 1: the single clock; all logic SHALL run on its rising edge.
- REQ-004 Port rst, input, 1: reset, asynchronous and active-low.
- REQ-005 Port pix_valid, input, 1: pix_data is valid this cycle.
- REQ-006 Port pix_data, input, 1: binary pixel, raster order (row 0 first, column 0 first).
- REQ-007 Port pix_ready, output, 1: block can take a pixel; a pixel is accepted when pix_valid && pix_ready at the clock edge.
- REQ-008 Port win_valid, output, 1: neighbors_state holds one window this cycle.
- REQ-009 Port neighbors_state, output, 9 (one bit per index 0..8): 3x3 window centred on (r,c), with this bit-to-pixel mapping:
  - bit0 = (r-1,c-1), bit1 = (r-1,c), bit2 = (r-1,c+1)
  - bit3 = (r,c+1), bit4 = (r+1,c+1), bit5 = (r+1,c)
  - bit6 = (r+1,c-1), bit7 = (r,c-1), bit8 = (r,c)
- REQ-010 Port frame_done, output, 1: one-cycle pulse coincident with the last window of a frame.

Function
- REQ-011 The block SHALL emit exactly IMG_W*IMG_H windows per frame, one per centre pixel, in raster order of centre.
- REQ-012 Any neighbour outside the image (row < 0, row >= IMG_H, col < 0, col >= IMG_W) SHALL read as 0, whatever the storage holds.
- REQ-013 Define idx(r,c) = r*IMG_W + c. The window for idx k SHALL be triggered by acceptance of the pixel with idx k+IMG_W+1, when that pixel exists.
- REQ-014 win_valid, neighbors_state and frame_done SHALL be registered and SHALL update on the clock edge after the triggering acceptance, giving 1-cycle latency.
- REQ-015 No window SHALL be emitted in a cycle with no acceptance, except in FLUSH; input gaps SHALL NOT change the window values or their order.
- REQ-016 Pixel storage SHALL be a shift structure of 2*IMG_W+3 bits that advances only on acceptance or on a flush step.
- REQ-017 The state machine SHALL have these states and transitions:
  - IDLE: pix_ready=1; on the first acceptance, go to FILL.
  - FILL: pix_ready=1; no windows; after IMG_W+1 pixels have been accepted, go to RUN.
  - RUN: pix_ready=1; one window per acceptance; after pixel idx IMG_W*IMG_H-1 is accepted, go to FLUSH.
  - FLUSH: pix_ready=0; shift in 0 each cycle, emitting one window per cycle for IMG_W+1 cycles; then go to IDLE.
- REQ-018 In FLUSH, pix_valid SHALL be ignored and no pixel SHALL be accepted.
- REQ-019 frame_done SHALL assert with the window for idx IMG_W*IMG_H-1 and be 0 in every other cycle.
- REQ-020 Row and column counters SHALL wrap from IMG_W-1 to 0 and from IMG_H-1 to 0 without overflow; their widths SHALL be ceil(log2) of the respective dimension, minimum 1.
- REQ-021 A new frame's first pixel SHALL be acceptable in the cycle after the last FLUSH cycle, with no residue from the previous frame.

Reset
- REQ-022 While rst=0, the block SHALL asynchronously force:
  - state IDLE;
  - all counters to 0;
  - win_valid=0, neighbors_state=0, frame_done=0;
  - pix_ready=1 in the first cycle after rst goes back to 1.
- REQ-023 Storage contents need not be cleared; the padding of REQ-012 SHALL mask them.
- REQ-024 A reset asserted mid-frame SHALL discard the partial frame; the next accepted pixel SHALL be idx 0 of a new frame.

Verification
- REQ-025 4x4 all-ones, pix_valid held high:
  - first win_valid one cycle after the 6th acceptance;
  - window (0,0) = 9'b100111000, window (1,1) = 9'h1FF, window (3,3) = 9'b110000011;
  - 16 windows in total; FLUSH lasts 5 cycles with pix_ready=0; frame_done with the 16th window.
- REQ-026 4x4 frame with a single 1 at (1,1):
  - window (1,1) = 9'h100;
  - window (0,0) = 9'h010, window (2,2) = 9'h001;
  - all other windows not adjacent to (1,1) = 0.
- REQ-027 Same 4x4 all-ones frame with pix_valid toggling every cycle: window sequence identical to REQ-025, and a window appears only after an acceptance.
- REQ-028 pix_valid held high through FLUSH: no acceptance occurs; the next frame starts after FLUSH and its window (0,0) ignores previous-frame data.
- REQ-029 rst pulsed low after 7 accepted pixels:
  - all outputs go to 0 immediately;
  - a following all-zero 4x4 frame yields 16 windows of 9'h000.
